uart_tx_fifo: RTL and testbench

//   Parametrised UART transmitter with input FIFO, configurable frame format (data bits, parity, stop bits).

---
 rtl/uart_tx_fifo.sv | 180 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter: FIFO-buffered ready/valid byte input, baud clock-enable counter, 5..9 data bits, optional parity, 1-2 stop bits.
// Push into an empty idle FIFO shows tx low 2 clocks later; tx_ready drops while the FIFO is full.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 1000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_valid,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV = CLK_FREQ / BAUD_RATE;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int IW  = $clog2(DATA_BITS);

  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
  localparam logic [AW:0]   FULL      = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         baud_q, baud_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  par_q, par_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DATA_BITS-1:0]  mem_q [FIFO_DEPTH];

  logic                  bit_end;
  logic                  stop_end;
  logic                  push;
  logic                  pop;
  logic [DATA_BITS-1:0]  head;

  assign tx_ready   = (count_q != FULL);
  assign fifo_count = count_q;
  assign tx         = tx_q;
  assign tx_busy    = busy_q;
  assign tx_done    = done_q;

  assign head     = mem_q[rd_ptr_q];
  assign bit_end  = (baud_q == BAUD_LAST);
  assign stop_end = (state_q == STOP) && bit_end && (idx_q == STOP_LAST);
  assign push     = tx_valid && tx_ready;
  assign pop      = (count_q != '0) && ((state_q == IDLE) || stop_end);

  // FIFO bookkeeping; a simultaneous push and pop leaves the count unchanged
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    baud_d  = '0;
    if (state_q != IDLE && !bit_end) baud_d = baud_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (pop) state_d = START;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == DATA_LAST) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          idx_d   = '0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (idx_q == STOP_LAST) begin
            state_d = pop ? START : IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The word is captured here, so later tx_data changes cannot touch this frame
    if (pop) begin
      shift_d = head;
      par_d   = (^head) ^ (PARITY_ODD != 0);
      baud_d  = '0;
    end
  end

  // Outputs are registered from the current state, so the line trails the FSM by one clock
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_q != IDLE);
    done_d = stop_end;
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[idx_q];
      PARITY:  tx_d = par_q;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four frame formats side by side, scoreboard of expected frames
// checked cycle by cycle by one monitor process per instance.
module tb_uart_tx_fifo;
  localparam int DIV = 10;
  localparam int NI  = 4;
  // instance 0: 8N1, 1: 8E1, 2: 8O1, 3: 7N2
  localparam int DB [NI] = '{8, 8, 8, 7};
  localparam int PE [NI] = '{0, 1, 1, 0};
  localparam int PO [NI] = '{0, 0, 1, 0};
  localparam int SB [NI] = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       rst;
  logic       tv    [NI];
  logic [7:0] td    [NI];
  logic       trdy  [NI];
  logic       txl   [NI];
  logic       tbusy [NI];
  logic       tdone [NI];
  logic [2:0] fc    [NI];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY_EN(0),
                 .PARITY_ODD(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst(rst), .tx_valid(tv[0]), .tx_data(td[0]), .tx_ready(trdy[0]),
    .tx(txl[0]), .tx_busy(tbusy[0]), .tx_done(tdone[0]), .fifo_count(fc[0]));
  uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY_EN(1),
                 .PARITY_ODD(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst(rst), .tx_valid(tv[1]), .tx_data(td[1]), .tx_ready(trdy[1]),
    .tx(txl[1]), .tx_busy(tbusy[1]), .tx_done(tdone[1]), .fifo_count(fc[1]));
  uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY_EN(1),
                 .PARITY_ODD(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
    .clk(clk), .rst(rst), .tx_valid(tv[2]), .tx_data(td[2]), .tx_ready(trdy[2]),
    .tx(txl[2]), .tx_busy(tbusy[2]), .tx_done(tdone[2]), .fifo_count(fc[2]));
  uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(7), .PARITY_EN(0),
                 .PARITY_ODD(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
    .clk(clk), .rst(rst), .tx_valid(tv[3]), .tx_data(td[3][6:0]), .tx_ready(trdy[3]),
    .tx(txl[3]), .tx_busy(tbusy[3]), .tx_done(tdone[3]), .fifo_count(fc[3]));

  int total = 0;
  int bad   = 0;

  // expected frames: bit i is the i-th bit on the line (start bit first)
  logic [15:0] exp_bits [NI][$];
  int          exp_len  [NI][$];

  int in_frame   [NI] = '{default: 0};
  int started    [NI] = '{default: 0};
  int done_cnt   [NI] = '{default: 0};
  int b2b        [NI] = '{default: 0};
  int last_start [NI] = '{default: 0};
  int last_done  [NI] = '{default: -10};
  int last_acc   [NI] = '{default: 0};

  always @(negedge clk)
    for (int i = 0; i < NI; i++)
      if (tdone[i] === 1'b1) done_cnt[i] <= done_cnt[i] + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, expv);
    end
  endtask

  function automatic logic [15:0] model(input int k, input logic [7:0] d);
    logic [15:0] f;
    logic        par;
    int          p;
    f   = '0;
    par = (PO[k] != 0);
    p   = 1;
    for (int i = 0; i < DB[k]; i++) begin
      f[p] = d[i];
      par  = par ^ d[i];
      p++;
    end
    if (PE[k] != 0) begin
      f[p] = par;
      p++;
    end
    for (int i = 0; i < SB[k]; i++) begin
      f[p] = 1'b1;
      p++;
    end
    return f;
  endfunction

  function automatic int flen(input int k);
    return 1 + DB[k] + PE[k] + SB[k];
  endfunction

  task automatic monitor(input int k);
    logic [15:0] eb;
    logic [15:0] got;
    int          el;
    logic        shape_ok;
    logic        aborted;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0 || txl[k] !== 1'b0) continue;
      if (exp_bits[k].size() == 0) begin
        chk($sformatf("unexpected_frame_i%0d", k), 1, 0);
        for (int w = 0; w < 200 && txl[k] === 1'b0; w++) @(negedge clk);
        continue;
      end
      eb = exp_bits[k].pop_front();
      el = exp_len[k].pop_front();
      in_frame[k] = 1;
      started[k]++;
      if (cyc == last_done[k] + 1) b2b[k]++;
      last_start[k] = cyc;
      got      = '0;
      shape_ok = 1'b1;
      aborted  = 1'b0;
      for (int j = 0; j < el * DIV; j++) begin
        if (j > 0) @(negedge clk);
        if (rst !== 1'b0) begin
          aborted = 1'b1;
          break;
        end
        if (j % DIV == DIV / 2) got[j / DIV] = txl[k];
        if (txl[k] !== eb[j / DIV]) shape_ok = 1'b0;
        if (tdone[k] !== (j == el * DIV - 1)) shape_ok = 1'b0;
        if (tbusy[k] !== 1'b1) shape_ok = 1'b0;
      end
      if (!aborted) begin
        chk($sformatf("frame_bits_i%0d", k), got, eb);
        chk($sformatf("frame_timing_i%0d", k), shape_ok, 1);
        last_done[k] = cyc;
      end
      in_frame[k] = 0;
    end
  endtask

  // call at a negedge; returns at the negedge after the accepting edge
  task automatic push(input int k, input logic [7:0] d, input logic [15:0] eb, input int el);
    int w;
    w     = 0;
    tv[k] = 1'b1;
    td[k] = d;
    while (trdy[k] !== 1'b1 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 3000) begin
      chk($sformatf("push_timeout_i%0d", k), 0, 1);
      tv[k] = 1'b0;
      return;
    end
    exp_bits[k].push_back(eb);
    exp_len[k].push_back(el);
    @(posedge clk);
    @(negedge clk);
    last_acc[k] = cyc;
    tv[k] = 1'b0;
    td[k] = ~d;
  endtask

  task automatic drain(input int k, input string name);
    int w;
    w = 0;
    while ((exp_bits[k].size() != 0 || in_frame[k] != 0 || tbusy[k] !== 1'b0) && w < 5000) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    chk(name, (w < 5000), 1);
  endtask

  task automatic wait_started(input int k, input int n, input string name);
    int w;
    w = 0;
    while (started[k] < n && w < 3000) begin
      @(negedge clk);
      w++;
    end
    chk(name, (w < 3000), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0, s0, b0, acc1, quiet_ok;
    for (int k = 0; k < NI; k++) begin
      tv[k] = 1'b0;
      td[k] = '0;
    end
    rst = 1'b1;
    fork
      monitor(0);
      monitor(1);
      monitor(2);
      monitor(3);
    join_none

    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rst_tx_i%0d", k), txl[k], 1);
      chk($sformatf("rst_busy_i%0d", k), tbusy[k], 0);
      chk($sformatf("rst_done_i%0d", k), tdone[k], 0);
      chk($sformatf("rst_ready_i%0d", k), trdy[k], 1);
      chk($sformatf("rst_count_i%0d", k), fc[k], 0);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // 8N1, 0xA5: line 0,1,0,1,0,0,1,0,1,1
    push(0, 8'hA5, 16'h034A, 10);
    wait_started(0, 1, "t1_start");
    chk("t1_latency", last_start[0] - last_acc[0], 2);
    drain(0, "t1_drain");
    chk("t1_done_pos", last_done[0] - last_start[0], 99);
    chk("t1_done_cnt", done_cnt[0], 1);
    chk("t1_busy_after", tbusy[0], 0);
    chk("t1_tx_idle", txl[0], 1);

    // 0xA5 has four ones: even parity 0, odd parity 1
    push(1, 8'hA5, 16'h054A, 11);
    push(2, 8'hA5, 16'h074A, 11);
    drain(1, "t2e_drain");
    drain(2, "t2o_drain");
    chk("t2e_len", last_done[1] - last_start[1], 109);
    chk("t2o_len", last_done[2] - last_start[2], 109);

    // 7 data bits, 2 stop bits
    push(3, 8'h7F, 16'h03FE, 10);
    drain(3, "t4_drain");
    chk("t4_len", last_done[3] - last_start[3], 99);
    chk("t4_done_cnt", done_cnt[3], 1);

    // fill the FIFO behind a frame in flight, then keep valid held while full
    d0 = done_cnt[0];
    s0 = started[0];
    b0 = b2b[0];
    push(0, 8'hFF, model(0, 8'hFF), flen(0));
    wait_started(0, s0 + 1, "t3_primer");
    @(negedge clk);
    push(0, 8'h01, model(0, 8'h01), flen(0));
    acc1 = last_acc[0];
    push(0, 8'h02, model(0, 8'h02), flen(0));
    push(0, 8'h03, model(0, 8'h03), flen(0));
    push(0, 8'h04, model(0, 8'h04), flen(0));
    chk("t3_consecutive", last_acc[0] - acc1, 3);
    chk("t3_ready_full", trdy[0], 0);
    chk("t3_count_full", fc[0], 4);
    push(0, 8'h05, model(0, 8'h05), flen(0));
    chk("t3_w5_after_pop", last_acc[0] - last_done[0], 1);
    push(0, 8'h06, model(0, 8'h06), flen(0));
    push(0, 8'h07, model(0, 8'h07), flen(0));
    chk("t6_ready_full", trdy[0], 0);
    chk("t6_count_full", fc[0], 4);
    drain(0, "t3_drain");
    chk("t3_frames", started[0] - s0, 8);
    chk("t3_dones", done_cnt[0] - d0, 8);
    chk("t3_back_to_back", b2b[0] - b0, 7);
    chk("t3_count_end", fc[0], 0);

    // reset during data bit 3 with two words still queued
    s0 = started[0];
    push(0, 8'h11, model(0, 8'h11), flen(0));
    push(0, 8'h22, model(0, 8'h22), flen(0));
    push(0, 8'h33, model(0, 8'h33), flen(0));
    wait_started(0, s0 + 1, "t5_start");
    for (int w = 0; w < 200 && cyc < last_start[0] + 45; w++) @(negedge clk);
    chk("t5_pre_count", fc[0], 2);
    @(posedge clk);
    #2 rst = 1'b1;
    exp_bits[0].delete();
    exp_len[0].delete();
    d0 = done_cnt[0];
    #1;
    chk("t5_tx_immediate", txl[0], 1);
    chk("t5_count", fc[0], 0);
    chk("t5_busy", tbusy[0], 0);
    chk("t5_ready", trdy[0], 1);
    @(posedge clk);
    #2 rst = 1'b0;
    quiet_ok = 1;
    for (int w = 0; w < 300; w++) begin
      @(negedge clk);
      if (txl[0] !== 1'b1 || tdone[0] !== 1'b0 || tbusy[0] !== 1'b0) quiet_ok = 0;
    end
    chk("t5_line_idle", quiet_ok, 1);
    chk("t5_no_done", done_cnt[0] - d0, 0);
    chk("t5_count_after", fc[0], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
